// File: rtl/aes_ctr_sched_pkg.sv
// rtl/aes_ctr_sched_pkg.sv - shared types and constants for the AES-CTR issue scheduler
package aes_ctr_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    AES_128 = 2'b00,
    AES_192 = 2'b01,
    AES_256 = 2'b10
  } key_size_t;

  // Two pipeline stages per round: 10, 12 or 14 rounds.
  localparam int LATENCY_AES_128 = 20;
  localparam int LATENCY_AES_192 = 24;
  localparam int LATENCY_AES_256 = 28;

  function automatic int default_latency(input key_size_t key_size);
    case (key_size)
      AES_192: return LATENCY_AES_192;
      AES_256: return LATENCY_AES_256;
      default: return LATENCY_AES_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_ctr_sched_if.sv
// rtl/aes_ctr_sched_if.sv - input FIFO, AES core and output FIFO handshake bundle
interface aes_ctr_sched_if;

  logic                            in_valid;
  logic                            in_pop;
  logic [aes_ctr_pkg::BLOCK_W-1:0] aes_in;
  logic                            out_push;
  logic                            credit_return;

  modport master (
    input  in_valid,
    input  credit_return,
    output in_pop,
    output aes_in,
    output out_push
  );

  modport slave (
    output in_valid,
    output credit_return,
    input  in_pop,
    input  aes_in,
    input  out_push
  );

endinterface

// File: rtl/aes_ctr_sched_valid_delay_line.sv
// rtl/aes_ctr_sched_valid_delay_line.sv - 1-bit shift register tracking blocks inside the AES core
module valid_delay_line #(
  parameter int DEPTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic valid,
  output logic tail,
  output logic any_valid
);

  logic [DEPTH-1:0] stages;
  logic [DEPTH-1:0] stages_next;

  always_comb begin
    stages_next = {stages[DEPTH-2:0], valid};
    if (flush) begin
      stages_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= stages_next;
    end
  end

  assign tail = stages[DEPTH-1];
  // Occupancy after the coming edge: low once the block at the tail is the last one.
  assign any_valid = |stages_next;

endmodule

// File: rtl/aes_ctr_sched.sv
// rtl/aes_ctr_sched.sv - credit-gated issue scheduler for the pipelined AES-128 CTR keystream
module aes_ctr_sched
  import aes_ctr_pkg::*;
#(
  parameter int LATENCY    = default_latency(AES_128),
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     number_blocks,
  input  logic [BLOCK_W-1:0]   ctr_iv,
  aes_ctr_sched_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     issued_count,
  output logic [CNT_W-1:0]     retired_count
);

  localparam int                  CREDIT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(FIFO_DEPTH);

  state_t               state;
  state_t               state_next;
  logic [CREDIT_W-1:0]  credit;
  logic [CNT_W-1:0]     remaining;
  logic [BLOCK_W-1:0]   ctr;
  logic                 aes_valid;
  logic                 issue;
  logic                 accept_start;
  logic                 line_tail;
  logic                 line_any_valid;

  assign accept_start = start && !abort && (state == IDLE || state == DONE);

  assign issue = !reset && !abort && (state == RUN) && bus.in_valid &&
                 (credit != '0) && (remaining != '0);

  assign bus.in_pop   = issue;
  assign bus.out_push = line_tail;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept_start) begin
          state_next = (number_blocks != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (issue && remaining == CNT_W'(1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!line_any_valid) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.aes_in    <= '0;
      aes_valid     <= 1'b0;
      ctr           <= '0;
      remaining     <= '0;
      credit        <= CREDIT_FULL;
      issued_count  <= '0;
      retired_count <= '0;
    end else begin
      state      <= state_next;
      bus.aes_in <= issue ? ctr_iv + ctr : '0;
      aes_valid  <= issue;
      if (accept_start) begin
        remaining     <= number_blocks;
        ctr           <= '0;
        credit        <= CREDIT_FULL;
        issued_count  <= '0;
        retired_count <= '0;
      end else begin
        if (issue) begin
          ctr          <= ctr + 1'b1;
          remaining    <= remaining - 1'b1;
          issued_count <= issued_count + 1'b1;
        end
        if (bus.out_push) begin
          retired_count <= retired_count + 1'b1;
        end
        // A return in the same cycle as an issue cancels out; a return into a full pool is dropped.
        if (issue && !bus.credit_return) begin
          credit <= credit - 1'b1;
        end else if (!issue && bus.credit_return && credit != CREDIT_FULL) begin
          credit <= credit + 1'b1;
        end
      end
    end
  end

  valid_delay_line #(
    .DEPTH(LATENCY)
  ) u_valid_delay_line (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .valid     (aes_valid),
    .tail      (line_tail),
    .any_valid (line_any_valid)
  );

  credit_overflow_chk : assert property (
    @(posedge clk) disable iff (reset)
    !(bus.credit_return && !issue && !accept_start && credit == CREDIT_FULL)
  );

endmodule

// File: tb/tb_aes_ctr_sched.sv
// tb/tb_aes_ctr_sched.sv - scoreboard testbench for aes_ctr_sched
module tb_aes_ctr_sched;
  import aes_ctr_pkg::*;

  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [CNT_W-1:0]   number_blocks = '0;
  logic [BLOCK_W-1:0] ctr_iv = '0;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   issued_count;
  logic [CNT_W-1:0]   retired_count;

  aes_ctr_sched_if bus ();

  aes_ctr_sched #(
    .LATENCY    (20),
    .FIFO_DEPTH (16),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .number_blocks (number_blocks),
    .ctr_iv        (ctr_iv),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .issued_count  (issued_count),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                 checks = 0;
  int                 failures = 0;
  int                 exp_pop[$];
  int                 exp_push[$];
  logic [BLOCK_W-1:0] exp_aes[$];
  int                 ret_cycles[$];
  bit                 pop_prev = 1'b0;
  bit                 push_seen = 1'b0;
  bit                 auto_ret = 1'b0;
  logic [BLOCK_W-1:0] mon_aes;
  int                 mon_cyc;

  task automatic chk(input bit ok, input string name, input logic [BLOCK_W-1:0] act,
                     input logic [BLOCK_W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pops, presents aes_in or pushes.
  always @(negedge clk) begin
    if (!reset) begin
      if (pop_prev) begin
        if (exp_aes.size() == 0) begin
          chk(1'b0, "aes_in_unexpected", bus.aes_in, '0);
        end else begin
          mon_aes = exp_aes.pop_front();
          chk(bus.aes_in === mon_aes, "aes_in", bus.aes_in, mon_aes);
        end
      end
      if (bus.in_pop === 1'b1) begin
        if (exp_pop.size() == 0) begin
          chk(1'b0, "in_pop_unexpected", BLOCK_W'(cyc), '0);
        end else begin
          mon_cyc = exp_pop.pop_front();
          chk(cyc == mon_cyc, "in_pop_cycle", BLOCK_W'(cyc), BLOCK_W'(mon_cyc));
        end
      end
      if (bus.out_push === 1'b1) begin
        if (exp_push.size() == 0) begin
          chk(1'b0, "out_push_unexpected", BLOCK_W'(cyc), '0);
        end else begin
          mon_cyc = exp_push.pop_front();
          chk(cyc == mon_cyc, "out_push_cycle", BLOCK_W'(cyc), BLOCK_W'(mon_cyc));
        end
      end
    end
    pop_prev  = !reset && (bus.in_pop === 1'b1);
    push_seen = !reset && (bus.out_push === 1'b1);
  end

  // Downstream model: returns credit one cycle after a push, plus scheduled returns.
  initial begin
    bus.credit_return = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.credit_return = auto_ret && push_seen;
      if (ret_cycles.size() != 0 && ret_cycles[0] == cyc) begin
        bus.credit_return = 1'b1;
        void'(ret_cycles.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_neg(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic begin_job(input logic [CNT_W-1:0] nb, input logic [BLOCK_W-1:0] iv,
                           output int t0);
    @(posedge clk);
    #1;
    start = 1'b1;
    number_blocks = nb;
    ctr_iv = iv;
    t0 = cyc;
  endtask

  task automatic end_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int t0;
    int t1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus.aes_in == '0, "rst_aes_in", bus.aes_in, '0);
    chk(bus.in_pop == 1'b0, "rst_in_pop", bus.in_pop, 0);
    chk(bus.out_push == 1'b0, "rst_out_push", bus.out_push, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(issued_count == '0, "rst_issued", issued_count, 0);
    chk(retired_count == '0, "rst_retired", retired_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 4 blocks with carry into the next byte, credit returned immediately.
    auto_ret = 1'b1;
    bus.in_valid = 1'b1;
    begin_job(16'd4, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00FE, t0);
    for (int i = 1; i <= 4; i++) exp_pop.push_back(t0 + i);
    for (int i = 22; i <= 25; i++) exp_push.push_back(t0 + i);
    exp_aes.push_back(128'hDEAD_BEEF_0000_0000_0000_0000_0000_00FE);
    exp_aes.push_back(128'hDEAD_BEEF_0000_0000_0000_0000_0000_00FF);
    exp_aes.push_back(128'hDEAD_BEEF_0000_0000_0000_0000_0000_0100);
    exp_aes.push_back(128'hDEAD_BEEF_0000_0000_0000_0000_0000_0101);
    end_start();
    wait_neg(t0 + 2);
    chk(busy == 1'b1, "t1_busy", busy, 1);
    wait_neg(t0 + 25);
    chk(done == 1'b0, "t1_done_early", done, 0);
    wait_neg(t0 + 26);
    chk(done == 1'b1, "t1_done", done, 1);
    chk(busy == 1'b0, "t1_busy_end", busy, 0);
    chk(retired_count == 16'd4, "t1_retired", retired_count, 4);
    chk(issued_count == 16'd4, "t1_issued", issued_count, 4);

    // Counter wrap at all-ones.
    begin_job(16'd2, {BLOCK_W{1'b1}}, t0);
    exp_pop.push_back(t0 + 1);
    exp_pop.push_back(t0 + 2);
    exp_aes.push_back({BLOCK_W{1'b1}});
    exp_aes.push_back('0);
    exp_push.push_back(t0 + 22);
    exp_push.push_back(t0 + 23);
    end_start();
    wait_neg(t0 + 24);
    chk(done == 1'b1, "t4_done", done, 1);
    chk(retired_count == 16'd2, "t4_retired", retired_count, 2);

    // in_valid gaps 1,0,1,0,1 propagate to out_push; 64-bit carry in the counter add.
    bus.in_valid = 1'b0;
    begin_job(16'd3, 128'hA5A5_A5A5_0000_0000_FFFF_FFFF_FFFF_FFFF, t0);
    exp_pop.push_back(t0 + 1);
    exp_pop.push_back(t0 + 3);
    exp_pop.push_back(t0 + 5);
    exp_aes.push_back(128'hA5A5_A5A5_0000_0000_FFFF_FFFF_FFFF_FFFF);
    exp_aes.push_back(128'hA5A5_A5A5_0000_0001_0000_0000_0000_0000);
    exp_aes.push_back(128'hA5A5_A5A5_0000_0001_0000_0000_0000_0001);
    exp_push.push_back(t0 + 22);
    exp_push.push_back(t0 + 24);
    exp_push.push_back(t0 + 26);
    end_start();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = pat[i];
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_neg(t0 + 27);
    chk(done == 1'b1, "t3_done", done, 1);
    chk(retired_count == 16'd3, "t3_retired", retired_count, 3);

    // 20 blocks, no returns: 16 issues then stall; each scheduled return frees one issue.
    auto_ret = 1'b0;
    bus.in_valid = 1'b1;
    begin_job(16'd20, 128'h1000, t0);
    for (int i = 0; i < 16; i++) begin
      exp_pop.push_back(t0 + 1 + i);
      exp_aes.push_back(128'h1000 + i);
      exp_push.push_back(t0 + 22 + i);
    end
    for (int k = 0; k < 4; k++) begin
      ret_cycles.push_back(t0 + 40 + 2 * k);
      exp_pop.push_back(t0 + 41 + 2 * k);
      exp_aes.push_back(128'h1010 + k);
      exp_push.push_back(t0 + 62 + 2 * k);
    end
    end_start();
    wait_neg(t0 + 30);
    chk(issued_count == 16'd16, "t2_stall_issued", issued_count, 16);
    chk(busy == 1'b1, "t2_stall_busy", busy, 1);
    wait_neg(t0 + 68);
    chk(done == 1'b0, "t2_done_early", done, 0);
    wait_neg(t0 + 69);
    chk(done == 1'b1, "t2_done", done, 1);
    chk(retired_count == 16'd20, "t2_retired", retired_count, 20);

    // Abort 5 cycles after first issue of an 8-block job.
    begin_job(16'd8, 128'h5, t0);
    for (int i = 0; i < 5; i++) begin
      exp_pop.push_back(t0 + 1 + i);
      exp_aes.push_back(128'h5 + i);
    end
    end_start();
    wait_neg(t0 + 5);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "t5_busy", busy, 0);
    chk(done == 1'b0, "t5_done", done, 0);
    chk(issued_count == 16'd5, "t5_issued_kept", issued_count, 5);
    chk(bus.aes_in == '0, "t5_aes_in", bus.aes_in, '0);
    wait_neg(t0 + 45);
    chk(retired_count == 16'd0, "t5_no_retire", retired_count, 0);

    // Restart after abort: 16 back-to-back issues need a fully refilled credit pool.
    begin_job(16'd16, 128'h100, t1);
    for (int i = 0; i < 16; i++) begin
      exp_pop.push_back(t1 + 1 + i);
      exp_aes.push_back(128'h100 + i);
      exp_push.push_back(t1 + 22 + i);
    end
    end_start();
    wait_neg(t1 + 38);
    chk(done == 1'b1, "t5_restart_done", done, 1);
    chk(retired_count == 16'd16, "t5_restart_retired", retired_count, 16);

    // start and abort together: abort wins, nothing issued.
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    number_blocks = 16'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk(done == 1'b0, "sa_done", done, 0);
    chk(busy == 1'b0, "sa_busy", busy, 0);
    repeat (5) @(negedge clk);

    // Zero-length job goes straight to DONE.
    begin_job(16'd0, '0, t0);
    end_start();
    @(negedge clk);
    chk(done == 1'b1, "t6_done", done, 1);
    chk(busy == 1'b0, "t6_busy", busy, 0);
    chk(issued_count == 16'd0, "t6_issued", issued_count, 0);
    chk(retired_count == 16'd0, "t6_retired", retired_count, 0);
    repeat (30) @(negedge clk);

    chk(exp_pop.size() == 0, "pop_queue_drained", BLOCK_W'(exp_pop.size()), '0);
    chk(exp_aes.size() == 0, "aes_queue_drained", BLOCK_W'(exp_aes.size()), '0);
    chk(exp_push.size() == 0, "push_queue_drained", BLOCK_W'(exp_push.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
